// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared CPU scheduler types: register index width, forward-select encodings,
// scheduler state enum and the shadow scoreboard entry.
package hazard_forward_ctrl_pkg;
  localparam int REG_W = 4;

  typedef logic [2:0] fwd_sel_t;
  localparam fwd_sel_t FWD_NONE = 3'd0;
  localparam fwd_sel_t FWD_WB   = 3'd1;
  localparam fwd_sel_t FWD_MEM  = 3'd2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;
endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage <-> scheduler bundle.
//   master: ID stage / memory side, drives decode fields and mem_busy.
//   slave : hazard_forward_ctrl, drives forward selects and pipe enables.
interface hazard_forward_ctrl_if;
  import hazard_forward_ctrl_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_branch_taken;
  logic             id_halt;
  logic             mem_busy;

  fwd_sel_t         forward_a;
  fwd_sel_t         forward_b;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_freeze;
  logic             halted;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_reg_write, id_mem_read, id_branch_taken, id_halt, mem_busy,
    input  forward_a, forward_b, pc_write_en, if_id_write_en, if_id_flush,
           id_ex_bubble, pipe_freeze, halted
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_reg_write, id_mem_read, id_branch_taken, id_halt, mem_busy,
    output forward_a, forward_b, pc_write_en, if_id_write_en, if_id_flush,
           id_ex_bubble, pipe_freeze, halted
  );
endinterface

// File: rtl/hazard_forward_ctrl_fwd_match.sv
// fwd_match: one source index vs one scoreboard entry.
//   i_src   source register index
//   i_uses  source is really read by the ID instruction
//   i_ent   shadow scoreboard entry
//   o_match entry produces i_src (R0 never matches: hardwired zero)
module fwd_match
  import hazard_forward_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_src,
  input  logic             i_uses,
  input  sb_entry_t        i_ent,
  output logic             o_match
);
  assign o_match = i_uses & i_ent.valid & i_ent.reg_write &
                   (i_ent.rd != '0) & (i_ent.rd == i_src);
endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: pipeline scheduler beside ID.
// Tracks in-flight destinations (sh_ex/sh_mem/sh_wb), registers the EX operand
// forward selects, generates PC / IF/ID / ID/EX enables and runs the HLT drain.
//   clk, rst_n : clock, async active-low reset
//   hz         : slave side of hazard_forward_ctrl_if
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_forward_ctrl_if.slave  hz
);
  sb_entry_t  r_sh_ex, r_sh_mem, r_sh_wb;
  fwd_sel_t   r_fwd_a, r_fwd_b;
  hz_state_t  r_state;
  logic [1:0] r_drain_cnt;
  logic       r_halted;

  // index 0 = rs/ex, index 1 = rt/mem
  logic      [1:0][REG_W-1:0] w_src;
  logic      [1:0]            w_uses;
  sb_entry_t [1:0]            w_ent;
  logic      [1:0][1:0]       w_match;   // [entry][source]

  assign w_src  = {hz.id_rt, hz.id_rs};
  assign w_uses = {hz.id_uses_rt, hz.id_uses_rs};
  assign w_ent  = {r_sh_mem, r_sh_ex};

  for (genvar e = 0; e < 2; e++) begin : g_ent
    for (genvar s = 0; s < 2; s++) begin : g_src
      fwd_match u_match (
        .i_src  (w_src[s]),
        .i_uses (w_uses[s]),
        .i_ent  (w_ent[e]),
        .o_match(w_match[e][s])
      );
    end
  end

  logic w_run, w_load_use, w_halt_go, w_kill;
  logic w_pc_en, w_ifid_en, w_flush, w_bubble;

  assign w_run      = (r_state == RUN);
  assign w_load_use = w_run & hz.id_valid & r_sh_ex.mem_read & (|w_match[0]);
  // HLT only takes effect on a clean advance; under a load-use stall it waits
  assign w_halt_go  = w_run & ~hz.mem_busy & ~w_load_use & hz.id_valid & hz.id_halt;

  always_comb begin
    w_pc_en   = 1'b1;
    w_ifid_en = 1'b1;
    w_flush   = 1'b0;
    w_bubble  = 1'b0;
    if (hz.mem_busy) begin
      w_pc_en   = 1'b0;
      w_ifid_en = 1'b0;
    end else if (!w_run || w_load_use) begin
      w_pc_en   = 1'b0;
      w_ifid_en = 1'b0;
      w_bubble  = 1'b1;
    end else begin
      w_pc_en   = ~w_halt_go;
      w_flush   = hz.id_branch_taken | w_halt_go;
    end
  end

  // HLT travels down as an invalid entry, same as a bubble
  assign w_kill = w_bubble | w_halt_go;

  sb_entry_t w_ex_next;
  always_comb begin
    w_ex_next = SB_EMPTY;
    if (hz.id_valid && !w_kill)
      w_ex_next = '{valid: 1'b1, rd: hz.id_rd, reg_write: hz.id_reg_write,
                    mem_read: hz.id_mem_read};
  end

  // sh_ex producer lands in MEM when the consumer reaches EX, so it wins
  fwd_sel_t w_fwd_a, w_fwd_b;
  always_comb begin
    w_fwd_a = FWD_NONE;
    w_fwd_b = FWD_NONE;
    if (!w_kill) begin
      if (w_match[0][0])      w_fwd_a = FWD_MEM;
      else if (w_match[1][0]) w_fwd_a = FWD_WB;
      if (w_match[0][1])      w_fwd_b = FWD_MEM;
      else if (w_match[1][1]) w_fwd_b = FWD_WB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_ex     <= SB_EMPTY;
      r_sh_mem    <= SB_EMPTY;
      r_sh_wb     <= SB_EMPTY;
      r_fwd_a     <= FWD_NONE;
      r_fwd_b     <= FWD_NONE;
      r_state     <= RUN;
      r_drain_cnt <= 2'd0;
      r_halted    <= 1'b0;
    end else if (!hz.mem_busy) begin
      r_sh_ex  <= w_ex_next;
      r_sh_mem <= r_sh_ex;
      r_sh_wb  <= r_sh_mem;
      r_fwd_a  <= w_fwd_a;
      r_fwd_b  <= w_fwd_b;
      case (r_state)
        RUN: if (w_halt_go) begin
          r_state     <= DRAIN;
          r_drain_cnt <= 2'd2;
        end
        DRAIN: begin
          // the edge that empties the counter is the one the last older
          // instruction retires on: HALTED lands 3 advances after HLT decode
          r_drain_cnt <= r_drain_cnt - 2'd1;
          if (r_drain_cnt == 2'd1) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hz.forward_a      = r_fwd_a;
  assign hz.forward_b      = r_fwd_b;
  assign hz.pc_write_en    = w_pc_en;
  assign hz.if_id_write_en = w_ifid_en;
  assign hz.if_id_flush    = w_flush;
  assign hz.id_ex_bubble   = w_bubble;
  assign hz.pipe_freeze    = hz.mem_busy;
  assign hz.halted         = r_halted;
endmodule
